// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

  localparam int unsigned FETCH_ADDR_W  = 4;
  localparam int unsigned FETCH_INSTR_W = 4;
  localparam int unsigned FETCH_DEPTH   = 4;
  localparam int unsigned PERF_CNT_W    = 8;

endpackage

// File: rtl/fetch_fifo.sv
// First-word fall-through prefetch queue with synchronous flush.
// Flush wins over push and pop; push is ignored when full, pop when empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // Storage array; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generator with req/ack memory handshake, prefetch
// queue toward decode, and redirect with abandoned-request discard.
// Optional FETCH_PERF_EN adds a saturating enqueued-instruction counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = FETCH_ADDR_W,
  parameter int unsigned INSTR_W = FETCH_INSTR_W,
  parameter int unsigned DEPTH   = FETCH_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_fetch_cnt
`endif
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  discard_addr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] head;
  logic               push;
  logic               pop;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state: a redirect with an unanswered request must swallow its ack.
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = (imem_req && !imem_ack) ? DISCARD : RUN;
    end else if (state == DISCARD && imem_ack) begin
      state_nxt = RUN;
    end
  end

  // Request, address and queue strobes; request held low while in reset.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc;
    if (state == DISCARD) begin
      imem_req  = reset;
      imem_addr = discard_addr;
    end else begin
      imem_req  = reset && (count < CNT_W'(DEPTH));
    end
    push = (state == RUN) && imem_req && imem_ack && !redirect_valid && !full;
    pop  = instr_valid && instr_ready && !redirect_valid;
  end

  // Fetch PC: jump on redirect, advance on each enqueued instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              fetch_pc <= '0;
    else if (redirect_valid) fetch_pc <= redirect_pc;
    else if (push)           fetch_pc <= fetch_pc + 1'b1;
  end

  // Address of the request abandoned by a redirect, kept on the bus until acked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               discard_addr <= '0;
    else if (redirect_valid && state == RUN)  discard_addr <= fetch_pc;
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .wdata ({fetch_pc, imem_rdata}),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign instr_valid = !empty;
  assign instr_pc    = head[ENTRY_W-1:INSTR_W];
  assign instr_data  = head[INSTR_W-1:0];

`ifdef FETCH_PERF_EN
  // Saturating count of enqueued instructions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        perf_fetch_cnt <= '0;
    else if (push && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
  end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the processor's decode/execute path. It replaces the free-running `pc + 1` with a program-counter generator that runs a req/ack handshake against instruction memory. Fetched instructions, each tagged with its PC, are buffered in a small prefetch queue. The queue delivers them downstream over a valid/ready interface and supports a redirect input for future branch/jump support.

## Interface
- `ADDR_W`, 4: PC / instruction-memory address width.
- `INSTR_W`, 4: instruction width.
- `DEPTH`, 4: prefetch queue entries; must be a power of two and at least 2.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  ADDR_W  fetch address; stable while `imem_req` is high and not acked.
- `imem_ack`  in  1  memory response; `imem_rdata` is valid in this cycle.
- `imem_rdata`  in  INSTR_W  instruction returned by memory.
- `redirect_valid`  in  1  one-cycle pulse that restarts fetch at `redirect_pc`.
- `redirect_pc`  in  ADDR_W  new fetch address.
- `instr_valid`  out  1  queue head is valid.
- `instr_ready`  in  1  consumer accepts the head.
- `instr_data`  out  INSTR_W  head instruction.
- `instr_pc`  out  ADDR_W  PC of the head instruction.

## Operation
- FSM states are RUN and DISCARD. Reset enters RUN.
- Queue occupancy `count` ranges 0..DEPTH and is `$clog2(DEPTH)+1` bits wide.
- `fetch_pc` is held in a register and drives `imem_addr`.
- RUN:
  - `imem_req = (count < DEPTH)`.
  - On an edge with `imem_req && imem_ack && !redirect_valid`: push {`fetch_pc`, `imem_rdata`} and set `fetch_pc <= fetch_pc + 1`, modulo 2^ADDR_W (15 wraps to 0).
- DISCARD:
  - `imem_req = 1`, and `imem_addr` keeps the abandoned address.
  - On ack, the data is dropped, the FSM returns to RUN, and `fetch_pc` is already the redirect target.
- Redirect (edge with `redirect_valid`, either state):
  - Queue flushed (`count <= 0`).
  - `fetch_pc <= redirect_pc`.
  - A same-cycle pop is ignored, and a same-cycle ack response is dropped.
  - If `imem_req && !imem_ack` at that edge, the FSM enters DISCARD. Otherwise it stays in or returns to RUN.
- Pop on `instr_valid && instr_ready`. Push and pop in the same cycle leave `count` unchanged.
- Full queue: `imem_req` is low, so no push can occur. There is no pop lookahead.
- Empty queue: `instr_valid = 0`, and `instr_ready` is ignored.

## Timing
- Reset values:
  - `imem_req` 0, `imem_addr` 0, `fetch_pc` 0.
  - `instr_valid` 0, `instr_data` 0, `instr_pc` 0.
  - `count` 0, state RUN.
- Reset is asynchronous: assertion mid-handshake clears all state immediately, and any in-flight response is lost.
- First request: `imem_req` rises in the first cycle after reset deasserts, with `imem_addr` = 0.
- `imem_ack` may arrive in the same cycle as `imem_req`, which covers combinational memory. This sustains one fetch per cycle.
- Latency: an ack sampled at edge N gives `instr_valid` high in cycle N+1. The queue is first-word fall-through; head outputs are combinational from the storage registers.
- When a redirect is sampled at edge N, the first redirected request appears in cycle N+1 if no request was in flight. Otherwise it appears in the cycle after the discarded ack.
- While `instr_valid` is high and not popped, `instr_data` and `instr_pc` are stable.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds output `perf_fetch_cnt` (8 bits, reset 0).
  - Increments on every enqueued instruction and saturates at 255.
  - Discarded and flushed responses are not counted.
- `FETCH_PERF_EN` undefined: the port and its counter are absent, and behaviour is otherwise identical.

## Structure
- Package `fetch_pkg` holds:
  - `fetch_state_t` enum {RUN, DISCARD}.
  - Default constants `FETCH_ADDR_W` = 4, `FETCH_INSTR_W` = 4, `FETCH_DEPTH` = 4.
  - `PERF_CNT_W` = 8.
- Sub-module `fetch_fifo` provides:
  - DEPTH x (ADDR_W+INSTR_W) first-word fall-through storage.
  - Push, pop and synchronous flush, with `count`, `full` and `empty` outputs.
  - Flush has priority over push and pop.
- `fetch_unit` owns the FSM, `fetch_pc`, the request logic and the perf counter.

## Test plan
- Reset release with a zero-latency ack-always memory returning `addr ^ 4'hA`, and `instr_ready` = 1:
  - `instr_pc` sequence is 0,1,2,…,15,0.
  - `instr_data` matches `addr ^ 4'hA`.
  - One instruction per cycle after the first.
- `instr_ready` = 0 for 10 cycles:
  - After 4 acks, `imem_req` drops and the queue holds PCs 0–3.
  - Raising `instr_ready` drains them in order, and fetch resumes at PC 4.
- Redirect to PC 9 while `imem_req` is high and ack is delayed 3 cycles:
  - The FSM enters DISCARD and the late response is not enqueued.
  - The next `instr_pc` is 9, and the queue reads empty the cycle after the redirect.
- Redirect coincident with ack and with pop:
  - The acked data is dropped, the pop is ignored and `count` goes to 0.
  - Fetch restarts at `redirect_pc` with no DISCARD state.
- Assert `reset` asynchronously mid-DISCARD:
  - All outputs go to their reset values immediately.
  - After release, fetch restarts at PC 0.
- With `FETCH_PERF_EN`: run 300 fetches with 2 redirects inserted; `perf_fetch_cnt` saturates at 255.
